// File: rtl/slave_fifo_port.sv
// Slave-end controller for the CPC 40105 FIFO link: SI/SOB/WNR handshaking on a shared sd bus, exposed as tx/rx byte streams.
// Define SLAVE_FIFO_STATS_EN to build the tx_count/rx_count byte counters; otherwise both read as zero.
`timescale 1ns/1ps
module slave_fifo_port #(
    parameter int SETTLE_CYC  = 2,
    parameter int SI_MIN_CYC  = 2,
    parameter int SOB_LOW_CYC = 2,
    parameter int RECOV_CYC   = 3
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        fifo_slave_dir,
    input  logic        fifo_slave_dor,
    output logic        slave_fifo_si,
    output logic        slave_fifo_sob,
    output logic        slave_fifo_wnr,
    output logic [7:0]  sd_out,
    output logic        sd_oe,
    input  logic [7:0]  sd_in,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count
);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [3:0] SI_MIN_LAST = 4'(SI_MIN_CYC - 1);
    localparam logic [3:0] SOB_LAST    = 4'(SOB_LOW_CYC - 1);
    localparam logic [3:0] RECOV_LAST  = 4'(RECOV_CYC - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_TURN   = 3'd1,
        WR_SI     = 3'd2,
        WR_REC    = 3'd3,
        TURN_BACK = 3'd4,
        RD_SO     = 3'd5,
        RD_REC    = 3'd6
    } state_t;

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        dir_m_r, dir_s, dor_m_r, dor_s;
    logic        last_wr_r;
    logic        si_r, sob_r, wnr_r, tx_ready_r, rx_valid_r;
    logic [7:0]  sd_out_r, rx_data_r;
    logic        wr_ok_s, rd_ok_s, start_wr_s, start_rd_s, si_done_s;
    logic [3:0]  cnt_inc_s;

    // Two-flop synchronisers for the asynchronous FIFO status flags.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            dir_m_r <= 1'b0;
            dir_s   <= 1'b0;
            dor_m_r <= 1'b0;
            dor_s   <= 1'b0;
        end else begin
            dir_m_r <= fifo_slave_dir;
            dir_s   <= dir_m_r;
            dor_m_r <= fifo_slave_dor;
            dor_s   <= dor_m_r;
        end
    end

    // Operation arbitration: on a tie the op opposite to the last completed one wins.
    always_comb begin
        wr_ok_s   = tx_valid & dir_s;
        rd_ok_s   = dor_s & ~rx_valid_r;
        if (state_r != IDLE) begin
            start_wr_s = 1'b0;
            start_rd_s = 1'b0;
        end else if (wr_ok_s && rd_ok_s) begin
            start_wr_s = ~last_wr_r;
            start_rd_s = last_wr_r;
        end else begin
            start_wr_s = wr_ok_s;
            start_rd_s = rd_ok_s;
        end
        si_done_s = (state_r == WR_SI) && (cnt_r >= SI_MIN_LAST) && !dir_s;
        cnt_inc_s = (cnt_r == 4'hF) ? 4'hF : cnt_r + 4'd1;
    end

    // Link sequencer; every pin and stream handshake comes straight from a flop.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            last_wr_r  <= 1'b0;
            si_r       <= 1'b0;
            sob_r      <= 1'b1;
            wnr_r      <= 1'b0;
            sd_out_r   <= 8'h00;
            tx_ready_r <= 1'b0;
            rx_valid_r <= 1'b0;
            rx_data_r  <= 8'h00;
        end else begin
            tx_ready_r <= 1'b0;
            if (rx_valid_r && rx_ready) begin
                rx_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    cnt_r <= 4'd0;
                    if (start_wr_s) begin
                        wnr_r      <= 1'b1;
                        sd_out_r   <= tx_data;
                        tx_ready_r <= 1'b1;
                        state_r    <= WR_TURN;
                    end else if (start_rd_s) begin
                        // Byte is already on sd (wnr low), so capture it before SOB moves the FIFO.
                        rx_data_r  <= sd_in;
                        rx_valid_r <= 1'b1;
                        sob_r      <= 1'b0;
                        state_r    <= RD_SO;
                    end
                end
                WR_TURN: begin
                    if (cnt_r == SETTLE_LAST) begin
                        si_r    <= 1'b1;
                        cnt_r   <= 4'd0;
                        state_r <= WR_SI;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                WR_SI: begin
                    if (si_done_s) begin
                        si_r    <= 1'b0;
                        cnt_r   <= 4'd0;
                        state_r <= WR_REC;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                WR_REC: begin
                    if (cnt_r == RECOV_LAST) begin
                        wnr_r   <= 1'b0;
                        cnt_r   <= 4'd0;
                        state_r <= TURN_BACK;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                TURN_BACK: begin
                    if (cnt_r == SETTLE_LAST) begin
                        last_wr_r <= 1'b1;
                        cnt_r     <= 4'd0;
                        state_r   <= IDLE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                RD_SO: begin
                    if (cnt_r == SOB_LAST) begin
                        sob_r   <= 1'b1;
                        cnt_r   <= 4'd0;
                        state_r <= RD_REC;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                RD_REC: begin
                    if (cnt_r == RECOV_LAST) begin
                        last_wr_r <= 1'b0;
                        cnt_r     <= 4'd0;
                        state_r   <= IDLE;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    si_r    <= 1'b0;
                    sob_r   <= 1'b1;
                    wnr_r   <= 1'b0;
                    cnt_r   <= 4'd0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef SLAVE_FIFO_STATS_EN
    logic [15:0] tx_count_r, rx_count_r;

    // Free-running byte counters, wrapping at 16 bits.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            tx_count_r <= 16'h0000;
            rx_count_r <= 16'h0000;
        end else begin
            if (si_done_s) begin
                tx_count_r <= tx_count_r + 16'd1;
            end
            if (start_rd_s) begin
                rx_count_r <= rx_count_r + 16'd1;
            end
        end
    end

    assign tx_count = tx_count_r;
    assign rx_count = rx_count_r;
`else
    assign tx_count = 16'h0000;
    assign rx_count = 16'h0000;
`endif

    assign slave_fifo_si  = si_r;
    assign slave_fifo_sob = sob_r;
    assign slave_fifo_wnr = wnr_r;
    assign sd_oe          = wnr_r;
    assign sd_out         = sd_out_r;
    assign tx_ready       = tx_ready_r;
    assign rx_valid       = rx_valid_r;
    assign rx_data        = rx_data_r;
endmodule
